// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU control decoder),
// datapath width, execution-unit state encoding and the single-cycle operation function.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int MUL_STEPS = DATA_W;
  localparam int CNT_W     = $clog2(MUL_STEPS);
  localparam int SHAMT_W   = $clog2(DATA_W);

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_XOR  = 3'd1;
  localparam logic [2:0] ALU_SLL  = 3'd2;
  localparam logic [2:0] ALU_ADD  = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;
  localparam logic [2:0] ALU_SRA  = 3'd6;
  localparam logic [2:0] ALU_RSVD = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // MUL is sequenced elsewhere; it and the reserved code yield 0 here.
  function automatic logic [DATA_W-1:0] alu_compute(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      ALU_SLL: res = a << b[SHAMT_W-1:0];
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_SRA: res = $signed(a) >>> b[SHAMT_W-1:0];
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per step, MUL_STEPS steps,
// returns the low DATA_W bits of the product.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt_q;

  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // product_o already includes the final step so the top can load it on that edge.
  assign product_o = acc_next;
  assign done_o    = step_i && (cnt_q == LAST_STEP);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle logic/shift/add ops and a 32-step multiply
// behind valid/ready handshakes on request and result sides.
//
//   state  | meaning
//   S_IDLE | waiting for a request, ready_o high
//   S_MUL  | multiply iterating, busy_o high
//   S_DONE | result_o valid, waiting for ready_i
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        ALUctl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              busy_o
);

  state_t            state_q;
  state_t            state_d;
  logic              ready_q;
  logic [DATA_W-1:0] result_q;
  logic              accept;
  logic              is_mul;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign accept    = valid_i && ready_q;
  assign is_mul    = (ALUctl_i == ALU_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_seq u_mul_seq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .step_i    (state_q == S_MUL),
    .mcand_i   (data1_i),
    .mplier_i  (data2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_mul ? S_MUL : S_DONE;
      S_MUL:   if (mul_done) state_d = S_DONE;
      S_DONE:  if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ready is registered so it stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      if (accept && !is_mul) begin
        result_q <= alu_compute(ALUctl_i, data1_i, data2_i);
      end else if ((state_q == S_MUL) && mul_done) begin
        result_q <= mul_product;
      end
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = (state_q == S_DONE);
  assign busy_o   = (state_q == S_MUL);
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand sequences for reset, backpressure and throughput.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  ALUctl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_unit dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ALUctl_i (ALUctl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural definition of each code.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] wide;
    int          sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return a << sh;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: begin
        wide = 64'(a) * 64'(b);
        return wide[31:0];
      end
      3'd6: begin
        wide = {{32{a[31]}}, a} >> sh;
        return wide[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int w;
    int lat;
    int busy;
    w = 0;
    while (!ready_o && w < 100) begin
      tick();
      w++;
    end
    chk($sformatf("%s ready_wait", tag), 32'(ready_o), 32'd1);
    if (!ready_o) return;
    valid_i  = 1'b1;
    ALUctl_i = op;
    data1_i  = a;
    data2_i  = b;
    ready_i  = 1'b0;
    tick();
    // operands must already be latched; scramble them
    valid_i  = 1'b0;
    data1_i  = $urandom;
    data2_i  = $urandom;
    ALUctl_i = 3'($urandom);
    lat  = 0;
    busy = 0;
    while (!valid_o && lat < 100) begin
      if (busy_o) busy++;
      tick();
      lat++;
    end
    chk($sformatf("%s op%0d result", tag, op), result_o, exp);
    chk($sformatf("%s op%0d latency", tag, op), 32'(lat + 1), (op == 3'd5) ? 32'd33 : 32'd1);
    chk($sformatf("%s op%0d busy_cycles", tag, op), 32'(busy), (op == 3'd5) ? 32'd32 : 32'd0);
    chk($sformatf("%s ready_low_in_done", tag), 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk($sformatf("%s valid_drop", tag), 32'(valid_o), 32'd0);
    chk($sformatf("%s ready_back", tag), 32'(ready_o), 32'd1);
    chk($sformatf("%s result_hold", tag), result_o, exp);
  endtask

  initial begin
    int cnt;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap"};
    tbl[1]  = '{3'd4, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, "sub_neg"};
    tbl[2]  = '{3'd6, 32'h8000_0000, 32'h4000_0004, 32'hF800_0000, "sra_imm_bit30"};
    tbl[3]  = '{3'd2, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "sll_31"};
    tbl[4]  = '{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1_m1"};
    tbl[5]  = '{3'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, "rsvd"};
    tbl[6]  = '{3'd1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, "xor_same"};
    tbl[7]  = '{3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, "and"};
    tbl[8]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, "mul_b0"};
    tbl[9]  = '{3'd5, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, "mul_small"};
    tbl[10] = '{3'd6, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000, "sra_pos"};
    tbl[11] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF, "sll_b_hi_ignored"};

    rst_i    = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    ALUctl_i = 3'd0;
    data1_i  = 32'h0;
    data2_i  = 32'h0;
    repeat (3) tick();
    chk("rst ready_o", 32'(ready_o), 32'd0);
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst result_o", result_o, 32'h0);
    chk("rst busy_o", 32'(busy_o), 32'd0);
    rst_i = 1'b1;
    tick();
    chk("post_rst ready_o", 32'(ready_o), 32'd1);

    for (int i = 0; i < 12; i++) run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op("rnd", rop, ra, rb, model(rop, ra, rb));
    end

    // Backpressure: result held, new requests refused while in DONE.
    valid_i  = 1'b1;
    ALUctl_i = 3'd3;
    data1_i  = 32'd5;
    data2_i  = 32'd6;
    tick();
    ALUctl_i = 3'd0;
    data1_i  = 32'hFFFF_FFFF;
    data2_i  = 32'h1234_0000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp valid_o c%0d", i), 32'(valid_o), 32'd1);
      chk($sformatf("bp result_o c%0d", i), result_o, 32'd11);
      chk($sformatf("bp ready_o c%0d", i), 32'(ready_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("bp release valid_o", 32'(valid_o), 32'd0);
    chk("bp release ready_o", 32'(ready_o), 32'd1);
    chk("bp release result_o", result_o, 32'd11);
    tick();
    chk("bp no_lost_accept valid_o", 32'(valid_o), 32'd0);

    // Back-to-back non-MUL throughput: one result every 2 cycles.
    cnt      = 0;
    valid_i  = 1'b1;
    ready_i  = 1'b1;
    ALUctl_i = 3'd3;
    data1_i  = 32'd100;
    data2_i  = 32'd23;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_o) cnt++;
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("throughput results", 32'(cnt), 32'd5);
    chk("throughput value", result_o, 32'd123);

    // Reset asserted mid-MUL discards the partial result.
    run_op("pre_rst", 3'd3, 32'd1, 32'd1, 32'd2);
    valid_i  = 1'b1;
    ALUctl_i = 3'd5;
    data1_i  = 32'd3;
    data2_i  = 32'd5;
    tick();
    valid_i = 1'b0;
    repeat (10) tick();
    chk("midmul busy_o", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("midmul rst valid_o", 32'(valid_o), 32'd0);
    chk("midmul rst result_o", result_o, 32'h0);
    chk("midmul rst busy_o", 32'(busy_o), 32'd0);
    chk("midmul rst ready_o", 32'(ready_o), 32'd0);
    repeat (3) tick();
    chk("midmul held ready_o", 32'(ready_o), 32'd0);
    chk("midmul held result_o", result_o, 32'h0);
    rst_i = 1'b1;
    tick();
    chk("midmul release ready_o", 32'(ready_o), 32'd1);
    chk("midmul release valid_o", 32'(valid_o), 32'd0);
    chk("midmul release result_o", result_o, 32'h0);
    run_op("post_rst_mul", 3'd5, 32'd3, 32'd5, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execution unit that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. It sits in the EX stage of the RV32 datapath. A valid/ready handshake on both sides lets the core stall while an iterative multiply is in progress. Single-cycle operations complete in one cycle; MUL is computed by a 32-step shift-add sequence.

## Interface
- DATA_W, 32, operand/result width (only 32 is supported)
- MUL_STEPS, 32, multiply iterations; equals DATA_W
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- valid_i  input  1  request present on ALUctl_i/data1_i/data2_i
- ready_o  output  1  unit can accept a request
- ALUctl_i  input  3  operation code: 0 AND, 1 XOR, 2 SLL, 3 ADD, 4 SUB, 5 MUL, 6 SRA, 7 reserved
- data1_i  input  32  operand A (rs1)
- data2_i  input  32  operand B (rs2 or sign-extended immediate)
- valid_o  output  1  result_o holds a completed result
- ready_i  input  1  consumer accepts result
- result_o  output  32  result
- busy_o  output  1  high in MUL state

## Operation
- States: IDLE, MUL, DONE. Reset state IDLE.
- ready_o = 1 only in IDLE. Request accepted when valid_i && ready_o; operands and code are latched at acceptance and ignored afterwards.
- IDLE, accepted, code != 5: compute result, register into result_o, go to DONE.
- IDLE, accepted, code == 5: load multiplicand = A, multiplier = B, accumulator = 0, step counter = 0, go to MUL.
- MUL: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter += 1. After step MUL_STEPS-1 (counter 31), load acc into result_o and go to DONE.
- DONE: valid_o = 1. When ready_i = 1, go to IDLE. result_o holds its value until the next result is loaded.
- Arithmetic: AND/XOR bitwise. ADD/SUB modulo 2^32, no flags. SLL shifts A left by B[4:0]. SRA shifts A arithmetically right by B[4:0]; B[31:5] ignored (bit 30 of an srai immediate has no effect). MUL returns the low 32 bits of A*B; this is identical for signed and unsigned operands.
- Reserved code 7: result 0, one-cycle latency like the other non-MUL codes.

## Timing
- Reset values: ready_o 0 while reset is asserted and 1 from the first cycle after release; valid_o 0; result_o 0; busy_o 0. Counter and accumulator are 0.
- Non-MUL latency: accept at edge N, valid_o high after edge N.
- MUL latency: accept at edge N; busy_o high for cycles N+1..N+32; valid_o high after edge N+32.
- valid_o stays high until a cycle in which ready_i = 1; it drops and ready_o rises after that edge. Back-to-back throughput for non-MUL codes is one request per 2 cycles.
- ready_i is ignored outside DONE. valid_i is ignored outside IDLE; no request is lost because ready_o is 0 there.
- Reset asserted mid-MUL or in DONE: immediate return to IDLE; the partial or pending result is discarded and result_o is 0.
- MUL with B = 0 still takes all 32 steps; there is no early termination.

## Structure
- Shared package alu_pkg: ALU_AND..ALU_SRA and ALU_RSVD code constants (shared with the ALU control decoder), state enum, DATA_W.
- Sub-module alu_mul_seq: holds the multiplicand/multiplier/accumulator registers and the counter. Inputs start and operands; outputs done and product. The top-level FSM sequences it.

## Test plan
- Reset: hold rst_i = 0 for 3 cycles during a MUL -> valid_o = 0, result_o = 0; ready_o = 1 one cycle after release.
- ADD 0xFFFFFFFF + 1 -> result_o = 0x00000000, valid_o one cycle after accept. SUB 3 - 5 -> 0xFFFFFFFE.
- SRA A = 0x80000000, B = 0x40000004 -> 0xF8000000. SLL A = 1, B = 31 -> 0x80000000.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001; busy_o high for exactly 32 cycles; valid_o on cycle 33.
- Backpressure: ready_i = 0 for 5 cycles in DONE -> valid_o and result_o stable, ready_o = 0, a new valid_i is not accepted; ready_i = 1 -> IDLE next cycle.
- Code 7 with A = B = 0xA5A5A5A5 -> result_o = 0. XOR of the same operands -> 0. AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
